// File: rtl/leds_pkg.sv
// -----------------------------------------------------------------------------
// leds_pkg
// Shared definitions for the LED pattern controller: mode encodings, register
// addresses, reset constants and a helper that maps a raw PERIOD value onto
// the step interval actually used (0 behaves as 1).
// -----------------------------------------------------------------------------
package leds_pkg;

    typedef enum logic [1:0] {
        MODE_DIRECT = 2'd0,
        MODE_BLINK  = 2'd1,
        MODE_PWM    = 2'd2,
        MODE_CHASE  = 2'd3
    } mode_e;

    localparam logic [1:0] ADDR_PATTERN = 2'd0;
    localparam logic [1:0] ADDR_MODE    = 2'd1;
    localparam logic [1:0] ADDR_DUTY    = 2'd2;
    localparam logic [1:0] ADDR_PERIOD  = 2'd3;

    localparam logic [7:0] PERIOD_RST   = 8'd1;

    // A PERIOD of zero would never produce a step; treat it as one tick.
    function automatic logic [7:0] eff_period(input logic [7:0] period);
        return (period == 8'd0) ? 8'd1 : period;
    endfunction

endpackage

// File: rtl/leds_timebase.sv
// -----------------------------------------------------------------------------
// leds_timebase
// Prescaler plus step counter. The prescaler divides the clock down to one
// tick every PRESCALE clocks; the step counter divides ticks by PERIOD.
//
// Ports:
//   i_clk      rising-edge clock
//   i_rst_n    synchronous active-low reset
//   clr_all    restart prescaler and step counter at this edge
//   clr_step   restart the step counter only at this edge
//   period     raw PERIOD register value (0 behaves as 1)
//   step       high for the cycle whose edge completes a PERIOD of ticks
// -----------------------------------------------------------------------------
module leds_timebase
    import leds_pkg::*;
#(
    parameter int PRESCALE = 1000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       clr_all,
    input  logic       clr_step,
    input  logic [7:0] period,
    output logic       step
);

    localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE - 1);

    logic [PRE_W-1:0] pre_cnt;
    logic [7:0]       step_cnt;
    logic             tick;
    logic             step_last;

    assign tick      = (pre_cnt == PRE_MAX);
    assign step_last = (step_cnt == (eff_period(period) - 8'd1));
    assign step      = tick && step_last;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            pre_cnt  <= '0;
            step_cnt <= '0;
        end else begin
            if (clr_all || tick) begin
                pre_cnt <= '0;
            end else begin
                pre_cnt <= pre_cnt + 1'b1;
            end

            if (clr_all || clr_step) begin
                step_cnt <= '0;
            end else if (tick) begin
                step_cnt <= step_last ? 8'd0 : step_cnt + 8'd1;
            end
        end
    end

endmodule

// File: rtl/leds_pattern_controller.sv
// -----------------------------------------------------------------------------
// leds_pattern_controller
// Drives NUM_LEDS LEDs from a write-only register bank in one of four modes:
// DIRECT, BLINK, PWM dimming and CHASE (rotate left).
//
// Ports:
//   i_clk    rising-edge clock
//   i_rst_n  synchronous active-low reset
//   i_we     register write strobe
//   i_addr   register select (PATTERN, MODE, DUTY, PERIOD)
//   i_data   write data; bits above each register's width are ignored
//   o_leds   registered LED drive
//
// Write handshake: there is no back-pressure. Every edge with i_we=1 is a
// completed write of i_data to register i_addr; i_addr/i_data are ignored
// when i_we=0. A write's register and side effects land at that edge and the
// LEDs show the result one edge later.
// -----------------------------------------------------------------------------
module leds_pattern_controller
    import leds_pkg::*;
#(
    parameter int NUM_LEDS = 4,
    parameter int DATA_W   = 8,
    parameter int PWM_W    = 4,
    parameter int PRESCALE = 1000
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_we,
    input  logic [1:0]          i_addr,
    input  logic [DATA_W-1:0]   i_data,
    output logic [NUM_LEDS-1:0] o_leds
);

    // Zero-extended copy so every register field can be sliced regardless
    // of how DATA_W compares with PWM_W or the 8-bit PERIOD field.
    localparam int EXT_W = DATA_W + PWM_W + 8;

    logic [EXT_W-1:0]    data_ext;
    logic                unused_data_bits;

    logic [NUM_LEDS-1:0] pattern_q;
    mode_e               mode_q;
    logic [PWM_W-1:0]    duty_q;
    logic [7:0]          period_q;
    logic                phase_q;
    logic [NUM_LEDS-1:0] chase_q;
    logic [PWM_W-1:0]    pwm_cnt;

    logic                wr_pattern;
    logic                wr_mode;
    logic                wr_duty;
    logic                wr_period;
    logic                step_raw;
    logic                step;
    logic                pwm_on;
    logic [NUM_LEDS-1:0] chase_rot;
    logic [NUM_LEDS-1:0] leds_d;

    assign data_ext         = EXT_W'(i_data);
    assign unused_data_bits = ^data_ext;

    assign wr_pattern = i_we && (i_addr == ADDR_PATTERN);
    assign wr_mode    = i_we && (i_addr == ADDR_MODE);
    assign wr_duty    = i_we && (i_addr == ADDR_DUTY);
    assign wr_period  = i_we && (i_addr == ADDR_PERIOD);

    leds_timebase #(
        .PRESCALE (PRESCALE)
    ) u_timebase (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .clr_all  (wr_mode),
        .clr_step (wr_period),
        .period   (period_q),
        .step     (step_raw)
    );

    // A MODE or PERIOD write restarts the interval, so a step landing on the
    // same edge is dropped.
    assign step = step_raw && !wr_mode && !wr_period;

    assign pwm_on = (pwm_cnt < duty_q);

    // Rotate left by one; with NUM_LEDS=1 both shifts cancel to identity.
    assign chase_rot = (chase_q << 1) | (chase_q >> (NUM_LEDS - 1));

    always_comb begin
        leds_d = '0;
        case (mode_q)
            MODE_DIRECT: leds_d = pattern_q;
            MODE_BLINK:  leds_d = phase_q ? pattern_q : '0;
            MODE_PWM:    leds_d = pattern_q & {NUM_LEDS{pwm_on}};
            MODE_CHASE:  leds_d = chase_q;
            default:     leds_d = '0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            pattern_q <= '0;
            mode_q    <= MODE_DIRECT;
            duty_q    <= '0;
            period_q  <= PERIOD_RST;
            phase_q   <= 1'b1;
            chase_q   <= '0;
            pwm_cnt   <= '0;
            o_leds    <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
            o_leds  <= leds_d;

            if (wr_pattern) pattern_q <= data_ext[NUM_LEDS-1:0];
            if (wr_mode)    mode_q    <= mode_e'(data_ext[1:0]);
            if (wr_duty)    duty_q    <= data_ext[PWM_W-1:0];
            if (wr_period)  period_q  <= data_ext[7:0];

            // A PATTERN write does not suppress the step, so BLINK keeps its
            // cadence while the pattern changes.
            if (wr_mode) begin
                phase_q <= 1'b1;
            end else if (step) begin
                phase_q <= ~phase_q;
            end

            // Loading a fresh pattern takes priority over the rotate.
            if (wr_mode) begin
                chase_q <= pattern_q;
            end else if (wr_pattern) begin
                chase_q <= data_ext[NUM_LEDS-1:0];
            end else if (step && (mode_q == MODE_CHASE)) begin
                chase_q <= chase_rot;
            end
        end
    end

endmodule

// File: tb/tb_leds_pattern_controller.sv
// -----------------------------------------------------------------------------
// tb_leds_pattern_controller
// Directed stimulus against a time-based behavioural model. The model keeps
// elapsed-edge and elapsed-tick counts and derives BLINK phase, CHASE position
// and PWM position from them arithmetically; its per-edge expectation is
// queued and compared against o_leds every cycle. Literal checks pin the
// model to hand-computed values.
// -----------------------------------------------------------------------------
module tb_leds_pattern_controller;

    localparam int NUM_LEDS = 4;
    localparam int DATA_W   = 8;
    localparam int PWM_W    = 4;
    localparam int PRESCALE = 4;
    localparam int LED_MASK = (1 << NUM_LEDS) - 1;

    logic                i_clk   = 1'b0;
    logic                i_rst_n = 1'b0;
    logic                i_we    = 1'b0;
    logic [1:0]          i_addr  = '0;
    logic [DATA_W-1:0]   i_data  = '0;
    logic [NUM_LEDS-1:0] o_leds;

    int n_cmp  = 0;
    int n_fail = 0;

    // ---------------- clock / reset ----------------
    always #5 i_clk = ~i_clk;

    leds_pattern_controller #(
        .NUM_LEDS (NUM_LEDS),
        .DATA_W   (DATA_W),
        .PWM_W    (PWM_W),
        .PRESCALE (PRESCALE)
    ) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_we    (i_we),
        .i_addr  (i_addr),
        .i_data  (i_data),
        .o_leds  (o_leds)
    );

    // ---------------- behavioural model ----------------
    bit m_valid = 0;
    int m_pattern, m_mode, m_duty, m_period;
    int m_edges;        // edges since the timebase was restarted
    int m_ticks;        // ticks since the step count was restarted
    int m_blink_steps;  // steps since the last MODE write
    int m_chase_base;   // value most recently loaded into the chase register
    int m_chase_steps;  // CHASE steps since that load
    int m_pwm_t;        // edges since reset

    logic [NUM_LEDS-1:0] exp_q[$];

    function automatic logic [NUM_LEDS-1:0] model_out();
        int v;
        case (m_mode)
            0: v = m_pattern;
            1: v = (m_blink_steps % 2 == 0) ? m_pattern : 0;
            2: v = ((m_pwm_t % (1 << PWM_W)) < m_duty) ? m_pattern : 0;
            default: begin
                v = m_chase_base;
                for (int i = 0; i < m_chase_steps % NUM_LEDS; i++)
                    v = ((v << 1) | (v >> (NUM_LEDS - 1))) & LED_MASK;
            end
        endcase
        return v[NUM_LEDS-1:0];
    endfunction

    always @(posedge i_clk) begin
        if (!i_rst_n) begin
            m_pattern = 0; m_mode = 0; m_duty = 0; m_period = 1;
            m_edges = 0; m_ticks = 0; m_blink_steps = 0;
            m_chase_base = 0; m_chase_steps = 0; m_pwm_t = 0;
            m_valid = 1;
            exp_q.push_back('0);
        end else begin
            bit tick, step;
            int per, d;
            exp_q.push_back(model_out());
            per  = (m_period == 0) ? 1 : m_period;
            tick = (m_edges % PRESCALE) == PRESCALE - 1;
            step = tick && ((m_ticks + 1) % per == 0);
            d    = int'(i_data);
            m_pwm_t++;
            m_edges++;
            if (tick) m_ticks++;
            if (i_we && i_addr == 2'd1) begin
                m_mode = d & 3;
                m_edges = 0; m_ticks = 0; m_blink_steps = 0;
                m_chase_base = m_pattern; m_chase_steps = 0;
            end else begin
                if (i_we && i_addr == 2'd3) begin
                    m_period = d & 255; m_ticks = 0; step = 0;
                end
                if (step) m_blink_steps++;
                if (i_we && i_addr == 2'd0) begin
                    m_pattern = d & LED_MASK;
                    m_chase_base = m_pattern; m_chase_steps = 0;
                end else if (step && m_mode == 3) begin
                    m_chase_steps++;
                end
                if (i_we && i_addr == 2'd2) m_duty = d & ((1 << PWM_W) - 1);
            end
        end
    end

    // ---------------- scoreboard ----------------
    always @(negedge i_clk) begin
        if (m_valid) begin
            logic [NUM_LEDS-1:0] e;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL cycle_cmp t=%0t expected queue empty, o_leds=%b", $time, o_leds);
            end else begin
                e = exp_q.pop_front();
                if (o_leds !== e) begin
                    n_fail++;
                    $display("FAIL cycle_cmp t=%0t o_leds=%b expected=%b", $time, o_leds, e);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wr(input logic [1:0] a, input logic [DATA_W-1:0] d);
        i_we   = 1'b1;
        i_addr = a;
        i_data = d;
        @(negedge i_clk);
        i_we   = 1'b0;
        i_addr = 2'($urandom_range(0, 3));
        i_data = DATA_W'($urandom_range(0, 255));
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge i_clk);
    endtask

    task automatic check_lit(input string name, input logic [NUM_LEDS-1:0] exp);
        n_cmp++;
        if (o_leds !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t o_leds=%b expected=%b", name, $time, o_leds, exp);
        end
    endtask

    task automatic check_pwm(input string name, input int exp_on);
        int on;
        on = 0;
        repeat (16) begin
            @(negedge i_clk);
            if (o_leds == 4'b1111) on++;
        end
        n_cmp++;
        if (on != exp_on) begin
            n_fail++;
            $display("FAIL %s on_clocks=%0d expected=%0d", name, on, exp_on);
        end
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        // 1. reset then DIRECT
        i_rst_n = 1'b0;
        wait_neg(3);
        check_lit("reset_leds", 4'b0000);
        i_rst_n = 1'b1;
        wr(2'd0, 8'hA5);
        check_lit("direct_one_edge", 4'b0000);
        wait_neg(1);
        check_lit("direct_a5", 4'b0101);

        // 2. BLINK, PERIOD=2 -> 8-clock half period
        wr(2'd0, 8'h03);
        wr(2'd3, 8'd2);
        wr(2'd1, 8'd1);
        wait_neg(1);  check_lit("blink_on", 4'b0011);
        wait_neg(7);  check_lit("blink_hold", 4'b0011);
        wait_neg(1);  check_lit("blink_off", 4'b0000);
        wait_neg(8);  check_lit("blink_on2", 4'b0011);

        // 6. MODE rewrite on the step edge suppresses the toggle
        wr(2'd1, 8'd1);
        wait_neg(7);
        wr(2'd1, 8'd1);
        wait_neg(1);  check_lit("rewrite_no_toggle", 4'b0011);
        wait_neg(7);  check_lit("rewrite_hold", 4'b0011);
        wait_neg(1);  check_lit("rewrite_toggle", 4'b0000);

        // PERIOD=0 behaves as 1 -> 4-clock half period
        wr(2'd3, 8'd0);
        wr(2'd1, 8'd1);
        wait_neg(1);  check_lit("p0_on", 4'b0011);
        wait_neg(4);  check_lit("p0_off", 4'b0000);
        wait_neg(4);  check_lit("p0_on2", 4'b0011);

        // 3. PWM
        wr(2'd0, 8'h0F);
        wr(2'd2, 8'd5);
        wr(2'd1, 8'd2);
        wait_neg(1);
        check_pwm("pwm_duty5", 5);
        wr(2'd2, 8'd0);
        wait_neg(1);
        check_pwm("pwm_duty0", 0);
        wr(2'd2, 8'hFF);  // upper bits ignored -> 15
        wait_neg(1);
        check_pwm("pwm_duty15", 15);

        // 4. CHASE
        wr(2'd0, 8'h01);
        wr(2'd3, 8'd1);
        wr(2'd1, 8'd3);
        wait_neg(1);  check_lit("chase_0", 4'b0001);
        wait_neg(4);  check_lit("chase_1", 4'b0010);
        wait_neg(4);  check_lit("chase_2", 4'b0100);
        wait_neg(4);  check_lit("chase_3", 4'b1000);
        wait_neg(4);  check_lit("chase_wrap", 4'b0001);
        wait_neg(2);
        wr(2'd0, 8'h03);  // lands on a step edge
        wait_neg(1);  check_lit("chase_load_wins", 4'b0011);
        wait_neg(4);  check_lit("chase_after_load", 4'b0110);

        // 5. mid-operation reset
        i_rst_n = 1'b0;
        wait_neg(1);
        i_rst_n = 1'b1;
        check_lit("reset_mid", 4'b0000);
        wait_neg(12); check_lit("no_rotate_after_rst", 4'b0000);

        // reset beats a simultaneous write
        i_rst_n = 1'b0;
        wr(2'd0, 8'hFF);
        i_rst_n = 1'b1;
        wait_neg(1);  check_lit("reset_beats_write", 4'b0000);

        // after reset the mode is DIRECT: pattern shows and stays static
        wr(2'd0, 8'h05);
        wait_neg(1);  check_lit("direct_after_rst", 4'b0101);
        wait_neg(10); check_lit("direct_static", 4'b0101);

        wait_neg(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
